// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, two-stage IR, bypass/ID registers, BSR strobes.
// Optional feature: define TAP_IDCODE_EN to build the ID register and make IDCODE the reset instruction.
module tap_controller #(
  parameter int unsigned IR_LEN     = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1923_4001
) (
  input  logic TCK,
  input  logic TRST,
  input  logic TMS,
  input  logic TDI,
  output logic TDO,
  output logic tdo_en,
  input  logic bsr_so,
  output logic bsr_capture,
  output logic bsr_shift,
  output logic bsr_update,
  output logic bsr_mode
);

  localparam logic [3:0] TLR    = 4'h0;
  localparam logic [3:0] RTI    = 4'h1;
  localparam logic [3:0] SEL_DR = 4'h2;
  localparam logic [3:0] CAP_DR = 4'h3;
  localparam logic [3:0] SH_DR  = 4'h4;
  localparam logic [3:0] EX1_DR = 4'h5;
  localparam logic [3:0] PAU_DR = 4'h6;
  localparam logic [3:0] EX2_DR = 4'h7;
  localparam logic [3:0] UPD_DR = 4'h8;
  localparam logic [3:0] SEL_IR = 4'h9;
  localparam logic [3:0] CAP_IR = 4'hA;
  localparam logic [3:0] SH_IR  = 4'hB;
  localparam logic [3:0] EX1_IR = 4'hC;
  localparam logic [3:0] PAU_IR = 4'hD;
  localparam logic [3:0] EX2_IR = 4'hE;
  localparam logic [3:0] UPD_IR = 4'hF;

  localparam logic [IR_LEN-1:0] EXTEST = '0;
  localparam logic [IR_LEN-1:0] SAMPLE = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] BYPASS = '1;
`ifdef TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] IDCODE    = IR_LEN'(2);
  localparam logic [IR_LEN-1:0] RST_INSTR = IDCODE;
`else
  localparam logic [IR_LEN-1:0] RST_INSTR = BYPASS;
`endif

  // Elaboration-time guard on illegal parameter values
  if (IR_LEN < 2 || IR_LEN > 8) begin : g_bad_ir_len
    $error("tap_controller: IR_LEN must be within 2..8");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
    $error("tap_controller: IDCODE_VAL bit 0 must be 1");
  end

  logic [3:0]        r_state;
  logic [3:0]        w_state_next;
  logic [IR_LEN-1:0] r_ir_sh;
  logic [IR_LEN-1:0] r_ir;
  logic [IR_LEN-1:0] w_ir_next;
  logic              r_bypass;
  logic              r_tdo;
  logic              r_tdo_en;
  logic              r_bsr_mode;
  logic              w_sel_bsr;
  logic              w_tdo;
  logic              w_tdo_en;
`ifdef TAP_IDCODE_EN
  logic [31:0]       r_idreg;
  logic              w_sel_id;
  assign w_sel_id = (r_ir == IDCODE);
`endif

  assign w_sel_bsr = (r_ir == EXTEST) || (r_ir == SAMPLE);

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) r_state <= TLR;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TLR:     w_state_next = TMS ? TLR    : RTI;
      RTI:     w_state_next = TMS ? SEL_DR : RTI;
      SEL_DR:  w_state_next = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  w_state_next = TMS ? EX1_DR : SH_DR;
      SH_DR:   w_state_next = TMS ? EX1_DR : SH_DR;
      EX1_DR:  w_state_next = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  w_state_next = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  w_state_next = TMS ? UPD_DR : SH_DR;
      UPD_DR:  w_state_next = TMS ? SEL_DR : RTI;
      SEL_IR:  w_state_next = TMS ? TLR    : CAP_IR;
      CAP_IR:  w_state_next = TMS ? EX1_IR : SH_IR;
      SH_IR:   w_state_next = TMS ? EX1_IR : SH_IR;
      EX1_IR:  w_state_next = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  w_state_next = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  w_state_next = TMS ? UPD_IR : SH_IR;
      UPD_IR:  w_state_next = TMS ? SEL_DR : RTI;
      default: w_state_next = TLR;
    endcase
  end

  // Rising-edge shift paths; every other state (pauses included) holds contents
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_ir_sh  <= '1;
      r_bypass <= 1'b0;
    end else begin
      if (r_state == TLR)        r_ir_sh <= '1;
      else if (r_state == CAP_IR) r_ir_sh <= IR_LEN'(1);
      else if (r_state == SH_IR)  r_ir_sh <= {TDI, r_ir_sh[IR_LEN-1:1]};
      if (r_state == TLR || r_state == CAP_DR) r_bypass <= 1'b0;
      else if (r_state == SH_DR)                r_bypass <= TDI;
    end
  end

`ifdef TAP_IDCODE_EN
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST)                              r_idreg <= IDCODE_VAL;
    else if (r_state == CAP_DR && w_sel_id) r_idreg <= IDCODE_VAL;
    else if (r_state == SH_DR && w_sel_id)  r_idreg <= {TDI, r_idreg[31:1]};
  end
`endif

  always_comb begin
    w_ir_next = r_ir;
    if (r_state == TLR)         w_ir_next = RST_INSTR;
    else if (r_state == UPD_IR) w_ir_next = r_ir_sh;
  end

  always_comb begin
    w_tdo    = 1'b0;
    w_tdo_en = 1'b0;
    if (r_state == SH_IR) begin
      w_tdo    = r_ir_sh[0];
      w_tdo_en = 1'b1;
    end else if (r_state == SH_DR) begin
      w_tdo_en = 1'b1;
      if (w_sel_bsr)     w_tdo = bsr_so;
`ifdef TAP_IDCODE_EN
      else if (w_sel_id) w_tdo = r_idreg[0];
`endif
      else               w_tdo = r_bypass;
    end
  end

  // Falling-edge stage: instruction update, TDO and glitch-free bsr_mode
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_ir       <= RST_INSTR;
      r_tdo      <= 1'b0;
      r_tdo_en   <= 1'b0;
      r_bsr_mode <= 1'b0;
    end else begin
      r_ir       <= w_ir_next;
      r_tdo      <= w_tdo;
      r_tdo_en   <= w_tdo_en;
      r_bsr_mode <= (w_ir_next == EXTEST);
    end
  end

  assign TDO         = r_tdo;
  assign tdo_en      = r_tdo_en;
  assign bsr_mode    = r_bsr_mode;
  assign bsr_capture = w_sel_bsr && (r_state == CAP_DR);
  assign bsr_shift   = w_sel_bsr && (r_state == SH_DR);
  assign bsr_update  = w_sel_bsr && (r_state == UPD_DR);

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller; expectations follow the TAP_IDCODE_EN setting of the build.
module tb_tap_controller;

  localparam logic [31:0] ID_VAL = 32'h1923_4001;

  logic TCK, TRST, TMS, TDI, bsr_so;
  logic TDO, tdo_en, bsr_capture, bsr_shift, bsr_update, bsr_mode;

  int n_cmp  = 0;
  int n_fail = 0;

  logic       s_tdo, s_en, s_mode;
  logic [3:0] ir_bits;
  logic       mode_upd;
  logic [31:0] pat;
  logic [1:0]  rst_scan;

  tap_controller #(.IR_LEN(4), .IDCODE_VAL(ID_VAL)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
    .bsr_so(bsr_so), .bsr_capture(bsr_capture), .bsr_shift(bsr_shift),
    .bsr_update(bsr_update), .bsr_mode(bsr_mode)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample outputs just after the falling edge, then apply TMS/TDI for the next rise
  task automatic step(input logic tms, input logic tdi);
    @(negedge TCK); #1;
    s_tdo  = TDO;
    s_en   = tdo_en;
    s_mode = bsr_mode;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK); #1;
  endtask

  // From RTI: scan val into the IR and return to RTI
  task automatic load_ir(input logic [3:0] val, output logic [3:0] tdo_bits, output logic mode_at_upd);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, val[i]);
      tdo_bits[i] = s_tdo;
    end
    step(1'b1, 1'b0);
    mode_at_upd = bsr_mode;
    step(1'b0, 1'b0);
  endtask

  initial begin
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; bsr_so = 1'b0;
    pat = 32'hA5C3_0F96;
`ifdef TAP_IDCODE_EN
    rst_scan = 2'b01;
`else
    rst_scan = 2'b10;
`endif
    #2 TRST = 1'b0;
    #20;
    check("rst_tdo", 32'(TDO), 32'd0);
    check("rst_tdo_en", 32'(tdo_en), 32'd0);
    check("rst_bsr_mode", 32'(bsr_mode), 32'd0);
    check("rst_strobes", 32'({bsr_capture, bsr_shift, bsr_update}), 32'd0);
    @(negedge TCK); #1 TRST = 1'b1;

    // First DR scan after reset
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("first_dr_bsr_shift", 32'(bsr_shift), 32'd0);
    for (int i = 0; i < 32; i++) begin
      step(i == 31, pat[i]);
`ifdef TAP_IDCODE_EN
      check($sformatf("idcode_bit%0d", i), 32'(s_tdo), 32'(ID_VAL[i]));
`else
      check($sformatf("first_dr_bit%0d", i), 32'(s_tdo), (i == 0) ? 32'd0 : 32'(pat[i-1]));
`endif
      if (i == 0 || i == 31) check("first_dr_tdo_en", 32'(s_en), 32'd1);
    end
    step(1'b1, 1'b0);
    check("ex1_dr_tdo_en", 32'(s_en), 32'd0);
    step(1'b0, 1'b0);

    // BYPASS instruction, captured IR pattern, one-cycle bypass delay
    load_ir(4'b1111, ir_bits, mode_upd);
    check("ir_capture_bits", 32'(ir_bits), 32'h1);
    check("bypass_mode", 32'(s_mode), 32'd0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); check("bypass_b0", 32'(s_tdo), 32'd0);
    step(1'b0, 1'b0); check("bypass_b1", 32'(s_tdo), 32'd1);
    step(1'b0, 1'b1); check("bypass_b2", 32'(s_tdo), 32'd0);
    step(1'b1, 1'b1); check("bypass_b3", 32'(s_tdo), 32'd1);
    step(1'b1, 1'b0); step(1'b0, 1'b0);

    // EXTEST: bsr_mode rises on the UPD_IR fall, then a BSR scan
    load_ir(4'b0000, ir_bits, mode_upd);
    check("extest_ir_first2", 32'(ir_bits[1:0]), 32'h1);
    check("extest_mode_before_fall", 32'(mode_upd), 32'd0);
    check("extest_mode_after_fall", 32'(s_mode), 32'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("bsr_capture_strobe", 32'({bsr_capture, bsr_shift, bsr_update}), 32'b100);
    step(1'b0, 1'b0);
    check("bsr_shift_strobe", 32'({bsr_capture, bsr_shift, bsr_update}), 32'b010);
    bsr_so = 1'b1; step(1'b0, 1'b0); check("bsr_so_b0", 32'(s_tdo), 32'd1);
    check("bsr_shift_hold", 32'(bsr_shift), 32'd1);
    bsr_so = 1'b0; step(1'b0, 1'b0); check("bsr_so_b1", 32'(s_tdo), 32'd0);
    bsr_so = 1'b1; step(1'b1, 1'b0); check("bsr_so_b2", 32'(s_tdo), 32'd1);
    bsr_so = 1'b0;
    step(1'b1, 1'b0);
    check("bsr_update_strobe", 32'({bsr_capture, bsr_shift, bsr_update}), 32'b001);
    step(1'b0, 1'b0);
    check("bsr_update_clear", 32'(bsr_update), 32'd0);

    // TRST mid Shift-IR discards the partial scan
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    check("mid_ir_tdo_en", 32'(s_en), 32'd1);
    check("mid_ir_mode_before", 32'(bsr_mode), 32'd1);
    #2 TRST = 1'b0;
    #1;
    check("async_tdo", 32'(TDO), 32'd0);
    check("async_tdo_en", 32'(tdo_en), 32'd0);
    check("async_bsr_mode", 32'(bsr_mode), 32'd0);
    @(negedge TCK); #1 TRST = 1'b1;
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("after_trst_bsr_shift", 32'(bsr_shift), 32'd0);
    step(1'b0, 1'b1); check("after_trst_b0", 32'(s_tdo), 32'(rst_scan[0]));
    step(1'b1, 1'b1); check("after_trst_b1", 32'(s_tdo), 32'(rst_scan[1]));
    check("after_trst_mode", 32'(s_mode), 32'd0);
    step(1'b1, 1'b0);
    check("after_trst_no_bsr_update", 32'(bsr_update), 32'd0);
    step(1'b0, 1'b0);

    // EXTEST again, park in Pause-DR, then five TMS=1 clocks back to TLR
    load_ir(4'b0000, ir_bits, mode_upd);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("pause_tdo_en", 32'(s_en), 32'd0);
    check("pause_mode", 32'(s_mode), 32'd1);
    check("pause_strobes", 32'({bsr_capture, bsr_shift, bsr_update}), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("tlr_mode", 32'(s_mode), 32'd0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("tlr_scan_en", 32'(s_en), 32'd1);
    check("tlr_scan_b0", 32'(s_tdo), 32'(rst_scan[0]));
    step(1'b1, 1'b1);
    check("tlr_scan_b1", 32'(s_tdo), 32'(rst_scan[1]));
    step(1'b1, 1'b0); step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
